scomp_control_unit: RTL and testbench

Multi-cycle sequencer for the accumulator CPU. It owns the fetch/decode/execute state register and turns the 8-bit opcode in IR[15:8] into per-cycle datapath strobes for PC, IR, AC, ALU, memory and I/O. Memory accesses use a ready handshake with a bounded wait. The block sits between the instruction register and the datapath; it exports its state code so the opcode-to-state mapping stays the single source of truth.

---
 rtl/scomp_pkg.sv | 96 +++++++++
 rtl/scomp_control_unit_if.sv | 38 +++
 rtl/scomp_mem_wait.sv | 32 +++
 rtl/scomp_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_scomp_control_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scomp_pkg.sv
// rtl/scomp_pkg.sv - shared state codes, ALU/mux encodings and opcodes for the SCOMP sequencer
package scomp_pkg;

   // Sequencer state codes; these values are exported on the state output.
   localparam logic [4:0] ST_RESET_PC = 5'h00;
   localparam logic [4:0] ST_FETCH    = 5'h01;
   localparam logic [4:0] ST_DECODE   = 5'h02;
   localparam logic [4:0] ST_ADD      = 5'h03;
   localparam logic [4:0] ST_STORE    = 5'h04;
   localparam logic [4:0] ST_ADDIND_2 = 5'h05;
   localparam logic [4:0] ST_LOAD     = 5'h07;
   localparam logic [4:0] ST_JUMP     = 5'h08;
   localparam logic [4:0] ST_JNEG     = 5'h09;
   localparam logic [4:0] ST_OUT      = 5'h0A;
   localparam logic [4:0] ST_XOR      = 5'h0B;
   localparam logic [4:0] ST_OR       = 5'h0C;
   localparam logic [4:0] ST_AND      = 5'h0D;
   localparam logic [4:0] ST_JPOS     = 5'h0E;
   localparam logic [4:0] ST_JZERO    = 5'h0F;
   localparam logic [4:0] ST_ADDI     = 5'h10;
   localparam logic [4:0] ST_SHL      = 5'h11;
   localparam logic [4:0] ST_SHR      = 5'h12;
   localparam logic [4:0] ST_SUB      = 5'h13;
   localparam logic [4:0] ST_RANDOM   = 5'h14;
   localparam logic [4:0] ST_ADDIND   = 5'h15;
   localparam logic [4:0] ST_ADDPCR   = 5'h16;

   // ALU function select.
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_PASS = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_SHR  = 4'd7;
   localparam logic [3:0] ALU_RAND = 4'd8;

   // Memory address source.
   localparam logic [1:0] ADDR_PC  = 2'd0;
   localparam logic [1:0] ADDR_IR  = 2'd1;
   localparam logic [1:0] ADDR_PTR = 2'd2;

   // ALU B operand source.
   localparam logic [1:0] BSEL_MEM = 2'd0;
   localparam logic [1:0] BSEL_IMM = 2'd1;
   localparam logic [1:0] BSEL_PC  = 2'd2;

   // Opcodes (IR[15:8]).
   localparam logic [7:0] OP_ADD    = 8'h00;
   localparam logic [7:0] OP_STORE  = 8'h01;
   localparam logic [7:0] OP_LOAD   = 8'h02;
   localparam logic [7:0] OP_JUMP   = 8'h03;
   localparam logic [7:0] OP_JNEG   = 8'h04;
   localparam logic [7:0] OP_SUB    = 8'h05;
   localparam logic [7:0] OP_XOR    = 8'h06;
   localparam logic [7:0] OP_OR     = 8'h07;
   localparam logic [7:0] OP_AND    = 8'h08;
   localparam logic [7:0] OP_JPOS   = 8'h09;
   localparam logic [7:0] OP_JZERO  = 8'h0A;
   localparam logic [7:0] OP_ADDI   = 8'h0B;
   localparam logic [7:0] OP_OUT    = 8'h0C;
   localparam logic [7:0] OP_SHL    = 8'h0D;
   localparam logic [7:0] OP_SHR    = 8'h0E;
   localparam logic [7:0] OP_RANDOM = 8'h35;
   localparam logic [7:0] OP_ADDIND = 8'h36;
   localparam logic [7:0] OP_ADDPCR = 8'h37;

   // Bundle of all combinational control outputs, so reset gating is one assignment.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [1:0] addr_sel;
      logic       ir_load;
      logic       pc_inc;
      logic       pc_load;
      logic       pc_clear;
      logic       ptr_load;
      logic       ac_load;
      logic       io_write;
      logic [3:0] alu_op;
      logic [1:0] alu_b_sel;
      logic       illegal_op;
      logic       bus_error;
   } ctrl_t;

   // States that hold a memory request open and use the wait counter.
   function automatic logic is_mem_state(input logic [4:0] st);
      case (st)
         ST_FETCH, ST_ADD, ST_STORE, ST_ADDIND_2, ST_LOAD,
         ST_XOR, ST_OR, ST_AND, ST_SUB, ST_ADDIND: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/scomp_control_unit_if.sv
// rtl/scomp_control_unit_if.sv - sequencer-to-datapath signal bundle
interface scomp_control_unit_if;
   logic [7:0] opcode;
   logic       ac_neg;
   logic       ac_zero;
   logic       mem_ready;
   logic [4:0] state;
   logic       mem_read;
   logic       mem_write;
   logic [1:0] addr_sel;
   logic       ir_load;
   logic       pc_inc;
   logic       pc_load;
   logic       pc_clear;
   logic       ptr_load;
   logic       ac_load;
   logic       io_write;
   logic [3:0] alu_op;
   logic [1:0] alu_b_sel;
   logic       illegal_op;
   logic       bus_error;

   // Sequencer side.
   modport master (
      input  opcode, ac_neg, ac_zero, mem_ready,
      output state, mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load,
             pc_clear, ptr_load, ac_load, io_write, alu_op, alu_b_sel,
             illegal_op, bus_error
   );

   // Datapath / memory side.
   modport slave (
      output opcode, ac_neg, ac_zero, mem_ready,
      input  state, mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load,
             pc_clear, ptr_load, ac_load, io_write, alu_op, alu_b_sel,
             illegal_op, bus_error
   );
endinterface

// File: rtl/scomp_mem_wait.sv
// rtl/scomp_mem_wait.sv - memory wait counter with bounded timeout
module scomp_mem_wait #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic ready_i,
   output logic done_o,
   output logic timeout_o
);
   localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // A ready on the limit cycle still counts as completion, so ready wins over timeout.
   assign done_o    = active_i && ready_i;
   assign timeout_o = active_i && !ready_i && (cnt_q == LIMIT);

   // Count stalled cycles; any completion, timeout or idle cycle clears, so each memory state starts at zero.
   always_comb begin
      cnt_d = '0;
      if (active_i && !ready_i && !timeout_o) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/scomp_control_unit.sv
// rtl/scomp_control_unit.sv - multi-cycle fetch/decode/execute sequencer for the SCOMP accumulator CPU
module scomp_control_unit
   import scomp_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst,
   scomp_control_unit_if.master bus
);
   logic [4:0] state_q, state_d;
   ctrl_t      ctrl, ctrl_o;
   logic       mem_done, mem_timeout;

   scomp_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk       (clk),
      .rst       (rst),
      .active_i  (is_mem_state(state_q)),
      .ready_i   (bus.mem_ready),
      .done_o    (mem_done),
      .timeout_o (mem_timeout)
   );

   // Next-state and per-cycle strobe decode; completion strobes are Mealy on mem_ready.
   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      case (state_q)
         ST_RESET_PC: begin
            ctrl.pc_clear = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.addr_sel = ADDR_PC;
            if (mem_done) begin
               ctrl.ir_load = 1'b1;
               ctrl.pc_inc  = 1'b1;
               state_d      = ST_DECODE;
            end else if (mem_timeout) begin
               ctrl.bus_error = 1'b1;
               state_d        = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (bus.opcode)
               OP_ADD:    state_d = ST_ADD;
               OP_STORE:  state_d = ST_STORE;
               OP_LOAD:   state_d = ST_LOAD;
               OP_JUMP:   state_d = ST_JUMP;
               OP_JNEG:   state_d = ST_JNEG;
               OP_SUB:    state_d = ST_SUB;
               OP_XOR:    state_d = ST_XOR;
               OP_OR:     state_d = ST_OR;
               OP_AND:    state_d = ST_AND;
               OP_JPOS:   state_d = ST_JPOS;
               OP_JZERO:  state_d = ST_JZERO;
               OP_ADDI:   state_d = ST_ADDI;
               OP_OUT:    state_d = ST_OUT;
               OP_SHL:    state_d = ST_SHL;
               OP_SHR:    state_d = ST_SHR;
               OP_RANDOM: state_d = ST_RANDOM;
               OP_ADDIND: state_d = ST_ADDIND;
               OP_ADDPCR: state_d = ST_ADDPCR;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  state_d         = ST_FETCH;
               end
            endcase
         end
         ST_ADD, ST_SUB, ST_XOR, ST_OR, ST_AND, ST_LOAD: begin
            ctrl.mem_read  = 1'b1;
            ctrl.addr_sel  = ADDR_IR;
            ctrl.alu_b_sel = BSEL_MEM;
            if (mem_done) begin
               ctrl.ac_load = 1'b1;
               case (state_q)
                  ST_SUB:  ctrl.alu_op = ALU_SUB;
                  ST_XOR:  ctrl.alu_op = ALU_XOR;
                  ST_OR:   ctrl.alu_op = ALU_OR;
                  ST_AND:  ctrl.alu_op = ALU_AND;
                  ST_LOAD: ctrl.alu_op = ALU_PASS;
                  default: ctrl.alu_op = ALU_ADD;
               endcase
               state_d = ST_FETCH;
            end else if (mem_timeout) begin
               ctrl.bus_error = 1'b1;
               state_d        = ST_FETCH;
            end
         end
         ST_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.addr_sel  = ADDR_IR;
            if (mem_done) begin
               state_d = ST_FETCH;
            end else if (mem_timeout) begin
               ctrl.bus_error = 1'b1;
               state_d        = ST_FETCH;
            end
         end
         ST_ADDIND: begin
            ctrl.mem_read = 1'b1;
            ctrl.addr_sel = ADDR_IR;
            if (mem_done) begin
               ctrl.ptr_load = 1'b1;
               state_d       = ST_ADDIND_2;
            end else if (mem_timeout) begin
               ctrl.bus_error = 1'b1;
               state_d        = ST_FETCH;
            end
         end
         ST_ADDIND_2: begin
            ctrl.mem_read  = 1'b1;
            ctrl.addr_sel  = ADDR_PTR;
            ctrl.alu_b_sel = BSEL_MEM;
            if (mem_done) begin
               ctrl.ac_load = 1'b1;
               ctrl.alu_op  = ALU_ADD;
               state_d      = ST_FETCH;
            end else if (mem_timeout) begin
               ctrl.bus_error = 1'b1;
               state_d        = ST_FETCH;
            end
         end
         ST_JUMP: begin
            ctrl.pc_load = 1'b1;
            state_d      = ST_FETCH;
         end
         ST_JNEG: begin
            ctrl.pc_load = bus.ac_neg;
            state_d      = ST_FETCH;
         end
         ST_JPOS: begin
            ctrl.pc_load = !bus.ac_neg && !bus.ac_zero;
            state_d      = ST_FETCH;
         end
         ST_JZERO: begin
            ctrl.pc_load = bus.ac_zero;
            state_d      = ST_FETCH;
         end
         ST_ADDI, ST_SHL, ST_SHR: begin
            ctrl.ac_load   = 1'b1;
            ctrl.alu_b_sel = BSEL_IMM;
            ctrl.alu_op    = (state_q == ST_SHL) ? ALU_SHL :
                             (state_q == ST_SHR) ? ALU_SHR : ALU_ADD;
            state_d        = ST_FETCH;
         end
         ST_RANDOM: begin
            ctrl.ac_load = 1'b1;
            ctrl.alu_op  = ALU_RAND;
            state_d      = ST_FETCH;
         end
         ST_ADDPCR: begin
            ctrl.ac_load   = 1'b1;
            ctrl.alu_b_sel = BSEL_PC;
            ctrl.alu_op    = ALU_ADD;
            state_d        = ST_FETCH;
         end
         ST_OUT: begin
            ctrl.io_write = 1'b1;
            state_d       = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State register; reset lands in reset_pc so the next fetch starts from PC 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_RESET_PC;
      else     state_q <= state_d;
   end

   // Force every strobe low while reset is held, so an open request drops immediately.
   assign ctrl_o = rst ? '0 : ctrl;

   assign bus.state      = state_q;
   assign bus.mem_read   = ctrl_o.mem_read;
   assign bus.mem_write  = ctrl_o.mem_write;
   assign bus.addr_sel   = ctrl_o.addr_sel;
   assign bus.ir_load    = ctrl_o.ir_load;
   assign bus.pc_inc     = ctrl_o.pc_inc;
   assign bus.pc_load    = ctrl_o.pc_load;
   assign bus.pc_clear   = ctrl_o.pc_clear;
   assign bus.ptr_load   = ctrl_o.ptr_load;
   assign bus.ac_load    = ctrl_o.ac_load;
   assign bus.io_write   = ctrl_o.io_write;
   assign bus.alu_op     = ctrl_o.alu_op;
   assign bus.alu_b_sel  = ctrl_o.alu_b_sel;
   assign bus.illegal_op = ctrl_o.illegal_op;
   assign bus.bus_error  = ctrl_o.bus_error;
endmodule

// File: tb/tb_scomp_control_unit.sv
// tb/tb_scomp_control_unit.sv - instruction-level trace model bench for scomp_control_unit
module tb_scomp_control_unit;
   localparam int T = 3;

   typedef struct packed {
      logic [4:0] st;
      logic       mr;
      logic       mw;
      logic [1:0] as;
      logic       irl;
      logic       pci;
      logic       pcl;
      logic       pcc;
      logic       ptl;
      logic       acl;
      logic       iow;
      logic [3:0] aop;
      logic [1:0] bs;
      logic       ill;
      logic       berr;
   } obs_t;

   typedef struct {
      bit   rdy;
      obs_t o;
   } cyc_t;

   logic clk = 1'b0;
   logic rst;
   int   checks;
   int   errors;
   cyc_t q[$];

   always #5 clk = ~clk;

   scomp_control_unit_if bus();
   scomp_control_unit #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t blank(input logic [4:0] st);
      obs_t o;
      o = '0;
      o.st = st;
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st = bus.state;     o.mr = bus.mem_read;  o.mw = bus.mem_write;
      o.as = bus.addr_sel;  o.irl = bus.ir_load;  o.pci = bus.pc_inc;
      o.pcl = bus.pc_load;  o.pcc = bus.pc_clear; o.ptl = bus.ptr_load;
      o.acl = bus.ac_load;  o.iow = bus.io_write; o.aop = bus.alu_op;
      o.bs = bus.alu_b_sel; o.ill = bus.illegal_op; o.berr = bus.bus_error;
      return o;
   endfunction

   task automatic push(input bit rdy, input obs_t o);
      cyc_t c;
      c.rdy = rdy;
      c.o   = o;
      q.push_back(c);
   endtask

   // Replay the expected trace: drive mem_ready after the edge, compare mid-cycle.
   task automatic run_q();
      cyc_t c;
      obs_t o;
      while (q.size() > 0) begin
         c = q.pop_front();
         bus.mem_ready = c.rdy;
         @(negedge clk);
         o = observe();
         check("state", 32'(o.st), 32'(c.o.st));
         check("ctl", 32'(o), 32'(c.o));
         @(posedge clk);
         #1;
      end
   endtask

   // One memory access: w wait cycles before ready; more than T waits means a timeout.
   task automatic mem_phase(input obs_t base, input obs_t fin, input int w, output bit ok);
      obs_t e;
      for (int i = 0; i <= T; i++) begin
         if (i == w) begin
            push(1'b1, fin);
            ok = 1'b1;
            return;
         end
         if (i == T) begin
            e = base;
            e.berr = 1'b1;
            push(1'b0, e);
            ok = 1'b0;
            return;
         end
         push(1'b0, base);
      end
      ok = 1'b0;
   endtask

   function automatic int rw(input int w);
      return (w < 0) ? int'($urandom_range(0, T + 2)) : w;
   endfunction

   // Build and replay the full cycle trace of one instruction.
   task automatic do_instr(input logic [7:0] op, input bit neg, input bit zero,
                           input int fw, input int ew1, input int ew2);
      obs_t base, fin, o;
      bit   ok;
      int   w;
      logic [4:0] st;
      logic [3:0] a;
      bus.opcode  = op;
      bus.ac_neg  = neg;
      bus.ac_zero = zero;
      w = fw;
      for (int k = 0; k < 40; k++) begin
         w = (k == 39) ? 0 : rw(w);
         base = blank(5'h01); base.mr = 1'b1;
         fin = base; fin.irl = 1'b1; fin.pci = 1'b1;
         mem_phase(base, fin, w, ok);
         if (ok) break;
         w = -1;
      end
      o = blank(5'h02);
      case (op)
         8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
         8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h35, 8'h36, 8'h37: ;
         default: o.ill = 1'b1;
      endcase
      push(1'($urandom), o);
      if (o.ill) begin
         run_q();
         return;
      end
      case (op)
         8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h02: begin
            case (op)
               8'h00:   begin st = 5'h03; a = 4'd0; end
               8'h05:   begin st = 5'h13; a = 4'd1; end
               8'h06:   begin st = 5'h0B; a = 4'd2; end
               8'h07:   begin st = 5'h0C; a = 4'd3; end
               8'h08:   begin st = 5'h0D; a = 4'd4; end
               default: begin st = 5'h07; a = 4'd5; end
            endcase
            base = blank(st); base.mr = 1'b1; base.as = 2'd1;
            fin = base; fin.acl = 1'b1; fin.aop = a;
            mem_phase(base, fin, rw(ew1), ok);
         end
         8'h01: begin
            base = blank(5'h04); base.mw = 1'b1; base.as = 2'd1;
            mem_phase(base, base, rw(ew1), ok);
         end
         8'h36: begin
            base = blank(5'h15); base.mr = 1'b1; base.as = 2'd1;
            fin = base; fin.ptl = 1'b1;
            mem_phase(base, fin, rw(ew1), ok);
            if (ok) begin
               base = blank(5'h05); base.mr = 1'b1; base.as = 2'd2;
               fin = base; fin.acl = 1'b1; fin.aop = 4'd0;
               mem_phase(base, fin, rw(ew2), ok);
            end
         end
         default: begin
            case (op)
               8'h03: begin o = blank(5'h08); o.pcl = 1'b1; end
               8'h04: begin o = blank(5'h09); o.pcl = neg; end
               8'h09: begin o = blank(5'h0E); o.pcl = !neg && !zero; end
               8'h0A: begin o = blank(5'h0F); o.pcl = zero; end
               8'h0B: begin o = blank(5'h10); o.acl = 1'b1; o.bs = 2'd1; o.aop = 4'd0; end
               8'h0D: begin o = blank(5'h11); o.acl = 1'b1; o.bs = 2'd1; o.aop = 4'd6; end
               8'h0E: begin o = blank(5'h12); o.acl = 1'b1; o.bs = 2'd1; o.aop = 4'd7; end
               8'h35: begin o = blank(5'h14); o.acl = 1'b1; o.aop = 4'd8; end
               8'h37: begin o = blank(5'h16); o.acl = 1'b1; o.bs = 2'd2; o.aop = 4'd0; end
               default: begin o = blank(5'h0A); o.iow = 1'b1; end
            endcase
            push(1'($urandom), o);
         end
      endcase
      run_q();
   endtask

   logic [7:0] legal_ops [18] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h35, 8'h36, 8'h37};

   initial begin
      obs_t o;
      bit   ok;
      logic [7:0] op;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode = 8'h00;
      bus.ac_neg = 1'b0;
      bus.ac_zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(bus.state), 32'h00);
      check("rst_ctl", 32'(observe()), 32'(blank(5'h00)));
      @(posedge clk);
      #1;
      rst = 1'b0;
      o = blank(5'h00); o.pcc = 1'b1;
      push(1'b1, o);
      run_q();

      do_instr(8'h02, 1'b0, 1'b0, 0, 3, 0);
      do_instr(8'h04, 1'b0, 1'b0, 0, 0, 0);
      do_instr(8'h04, 1'b1, 1'b0, 0, 0, 0);
      do_instr(8'h09, 1'b0, 1'b1, 0, 0, 0);
      do_instr(8'h09, 1'b0, 1'b0, 0, 0, 0);
      do_instr(8'h0A, 1'b0, 1'b1, 0, 0, 0);
      do_instr(8'h0A, 1'b1, 1'b0, 0, 0, 0);
      do_instr(8'h36, 1'b0, 1'b0, 0, 0, 0);
      do_instr(8'h0B, 1'b0, 1'b0, T + 1, 0, 0);
      do_instr(8'h0C, 1'b0, 1'b0, T, 0, 0);
      do_instr(8'h00, 1'b0, 1'b0, 0, T, 0);
      do_instr(8'h05, 1'b0, 1'b0, 0, T + 1, 0);
      do_instr(8'h36, 1'b0, 1'b0, 0, 1, T + 1);
      do_instr(8'hFF, 1'b0, 1'b0, 0, 0, 0);
      do_instr(8'h0F, 1'b0, 1'b0, 0, 0, 0);

      for (int n = 0; n < 120; n++) begin
         op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 17)];
         do_instr(op, 1'($urandom), 1'($urandom), -1, -1, -1);
      end

      // Reset in the middle of a stalled store.
      bus.opcode = 8'h01;
      o = blank(5'h01); o.mr = 1'b1;
      mem_phase(o, '{st: 5'h01, mr: 1'b1, irl: 1'b1, pci: 1'b1, default: '0}, 0, ok);
      push(1'b1, blank(5'h02));
      o = blank(5'h04); o.mw = 1'b1; o.as = 2'd1;
      push(1'b0, o);
      push(1'b0, o);
      run_q();
      bus.mem_ready = 1'b0;
      #2;
      check("store_mw_held", 32'(bus.mem_write), 32'h1);
      rst = 1'b1;
      #1;
      check("rst_mw_drop", 32'(bus.mem_write), 32'h0);
      check("rst_mid_state", 32'(bus.state), 32'h00);
      check("rst_mid_ctl", 32'(observe()), 32'(blank(5'h00)));
      @(posedge clk);
      #1;
      rst = 1'b0;
      o = blank(5'h00); o.pcc = 1'b1;
      push(1'b0, o);
      run_q();
      do_instr(8'h01, 1'b0, 1'b0, 0, 2, 0);
      do_instr(8'h37, 1'b0, 1'b0, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
